// File: rtl/lane_reduce_pkg.sv
// Shared definitions for the lane reduce/accumulate block.
//   DEF_WIDTH / DEF_LANES : default lane width and lane count
//   tag_t                 : per-level side-band (valid, last) carried with tree data
//   calc_stages()         : number of adder-tree levels for a lane count
//   lvl_off()             : element offset of a tree level in the flat tree bus
package lane_reduce_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_LANES = 64;

    typedef struct packed {
        logic valid;
        logic last;
    } tag_t;

    function automatic int calc_stages(input int lanes);
        return $clog2(lanes);
    endfunction

    // Levels are packed back to back: level 0 has LANES elements, level k has
    // LANES>>k, so level k starts at sum_{j<k} LANES>>j = 2*LANES - 2*(LANES>>k).
    function automatic int lvl_off(input int lanes, input int k);
        return (2 * lanes) - (2 * (lanes >> k));
    endfunction

endpackage

// File: rtl/lane_reduce_acc_adder_tree_level.sv
// One registered level of the reduction tree.
//   i_clk   : clock
//   i_reset : synchronous clear of data and tag
//   i_en    : advance enable; level holds when low
//   i_data  : N_IN packed elements from the previous level (element 0 in LSBs)
//   i_tag   : valid/last tag of the previous level
//   o_data  : N_IN/2 registered pairwise sums, wrapping at WIDTH bits
//   o_tag   : registered copy of i_tag
module adder_tree_level
    import lane_reduce_pkg::*;
#(
    parameter int N_IN  = 2,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_en,
    input  logic [N_IN*WIDTH-1:0]         i_data,
    input  tag_t                          i_tag,
    output logic [(N_IN/2)*WIDTH-1:0]     o_data,
    output tag_t                          o_tag
);

    localparam int N_OUT = N_IN / 2;

    logic [N_OUT*WIDTH-1:0] data_d;
    logic [N_OUT*WIDTH-1:0] data_q;
    tag_t                   tag_q;

    // Pairwise sums of adjacent elements; carries out of WIDTH are dropped.
    always_comb begin
        data_d = '0;
        for (int i = 0; i < N_OUT; i++) begin
            data_d[i*WIDTH +: WIDTH] = i_data[(2*i)*WIDTH +: WIDTH]
                                     + i_data[(2*i+1)*WIDTH +: WIDTH];
        end
    end

    // Level register with synchronous clear and stall hold.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            data_q <= '0;
            tag_q  <= '0;
        end else if (i_en) begin
            data_q <= data_d;
            tag_q  <= i_tag;
        end else begin
            data_q <= data_q;
            tag_q  <= tag_q;
        end
    end

    assign o_data = data_q;
    assign o_tag  = tag_q;

endmodule

// File: rtl/lane_reduce_acc.sv
// Reduces one beat of LANES lane values through a registered adder tree and
// accumulates up to ACC_COUNT reduced beats (fewer if a beat carries i_last)
// into one result presented on a valid/ready output.
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_valid/o_ready: input beat handshake; i_lanes packed lanes, lane 0 in LSBs
//   i_last         : beat closes the current accumulation
//   o_valid/i_ready: result handshake; o_val result, o_count beats in result
// A single enable stalls the whole pipeline while a result waits downstream.
module lane_reduce_acc
    import lane_reduce_pkg::*;
#(
    parameter int LANES     = DEF_LANES,
    parameter int WIDTH     = DEF_WIDTH,
    parameter int ACC_COUNT = 4
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic                           i_valid,
    output logic                           o_ready,
    input  logic [LANES*WIDTH-1:0]         i_lanes,
    input  logic                           i_last,
    output logic                           o_valid,
    input  logic                           i_ready,
    output logic [WIDTH-1:0]               o_val,
    output logic [$clog2(ACC_COUNT+1)-1:0] o_count
);

    localparam int STAGES = calc_stages(LANES);
    localparam int CW     = $clog2(ACC_COUNT + 1);
    localparam int TOTAL  = (2 * LANES) - 1;

    logic                    en_s;
    logic                    accept_s;
    logic [TOTAL*WIDTH-1:0]  tree_bus_s;
    tag_t                    tag_bus_s [0:STAGES];
    logic [WIDTH-1:0]        tree_out_s;
    tag_t                    tree_tag_s;
    logic [WIDTH-1:0]        sum_s;
    logic [CW-1:0]           cnt_s;
    logic                    close_s;

    logic [LANES*WIDTH-1:0]  lanes_q;
    tag_t                    tag0_d, tag0_q;
    logic [WIDTH-1:0]        acc_d, acc_q;
    logic [CW-1:0]           beat_d, beat_q;
    logic                    o_valid_d, o_valid_q;
    logic [WIDTH-1:0]        o_val_d, o_val_q;
    logic [CW-1:0]           o_count_d, o_count_q;

    // The pipeline only advances when no result is stuck waiting downstream.
    assign en_s     = !(o_valid_q && !i_ready);
    assign o_ready  = en_s && !i_reset;
    assign accept_s = i_valid && o_ready;

    // Input tag: last is only meaningful on an accepted beat.
    always_comb begin
        tag0_d.valid = accept_s;
        tag0_d.last  = accept_s && i_last;
    end

    // Input capture register forms level 0 of the tree.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            lanes_q <= '0;
            tag0_q  <= '0;
        end else if (en_s) begin
            lanes_q <= i_lanes;
            tag0_q  <= tag0_d;
        end else begin
            lanes_q <= lanes_q;
            tag0_q  <= tag0_q;
        end
    end

    assign tree_bus_s[LANES*WIDTH-1:0] = lanes_q;
    assign tag_bus_s[0]                = tag0_q;

    for (genvar k = 1; k <= STAGES; k++) begin : g_lvl
        adder_tree_level #(
            .N_IN  (LANES >> (k - 1)),
            .WIDTH (WIDTH)
        ) u_lvl (
            .i_clk   (i_clk),
            .i_reset (i_reset),
            .i_en    (en_s),
            .i_data  (tree_bus_s[lvl_off(LANES, k - 1)*WIDTH +: (LANES >> (k - 1))*WIDTH]),
            .i_tag   (tag_bus_s[k - 1]),
            .o_data  (tree_bus_s[lvl_off(LANES, k)*WIDTH +: (LANES >> k)*WIDTH]),
            .o_tag   (tag_bus_s[k])
        );
    end

    assign tree_out_s = tree_bus_s[(TOTAL - 1)*WIDTH +: WIDTH];
    assign tree_tag_s = tag_bus_s[STAGES];

    // Accumulate / output next state. With en high any held result is being
    // taken this edge, so o_valid drops unless a new result completes.
    always_comb begin
        sum_s     = acc_q + tree_out_s;
        cnt_s     = beat_q + CW'(1);
        close_s   = (cnt_s == CW'(ACC_COUNT)) || tree_tag_s.last;
        acc_d     = acc_q;
        beat_d    = beat_q;
        o_valid_d = o_valid_q;
        o_val_d   = o_val_q;
        o_count_d = o_count_q;
        if (en_s) begin
            o_valid_d = 1'b0;
            if (tree_tag_s.valid) begin
                if (close_s) begin
                    o_val_d   = sum_s;
                    o_count_d = cnt_s;
                    o_valid_d = 1'b1;
                    acc_d     = '0;
                    beat_d    = '0;
                end else begin
                    acc_d  = sum_s;
                    beat_d = cnt_s;
                end
            end else begin
                acc_d  = acc_q;
                beat_d = beat_q;
            end
        end else begin
            o_valid_d = o_valid_q;
        end
    end

    // Accumulator, beat counter and output registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            acc_q     <= '0;
            beat_q    <= '0;
            o_valid_q <= 1'b0;
            o_val_q   <= '0;
            o_count_q <= '0;
        end else begin
            acc_q     <= acc_d;
            beat_q    <= beat_d;
            o_valid_q <= o_valid_d;
            o_val_q   <= o_val_d;
            o_count_q <= o_count_d;
        end
    end

    assign o_valid = o_valid_q;
    assign o_val   = o_val_q;
    assign o_count = o_count_q;

endmodule

// File: tb/tb_lane_reduce_acc.sv
// Bench for lane_reduce_acc: two instances (ACC_COUNT=4 and ACC_COUNT=1) share
// one stimulus stream; each has its own reference model and scoreboard.
module tb_lane_reduce_acc;

    localparam int LANES = 64;
    localparam int WIDTH = 32;
    localparam int LW    = LANES * WIDTH;

    logic             clk = 1'b0;
    logic             rst;
    logic             i_valid;
    logic             i_last;
    logic             i_ready;
    logic [LW-1:0]    i_lanes;
    logic             o_ready4, o_valid4, o_ready1, o_valid1;
    logic [WIDTH-1:0] o_val4, o_val1;
    logic [2:0]       o_count4;
    logic [0:0]       o_count1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    lane_reduce_acc #(.LANES(LANES), .WIDTH(WIDTH), .ACC_COUNT(4)) dut4 (
        .i_clk(clk), .i_reset(rst), .i_valid(i_valid), .o_ready(o_ready4),
        .i_lanes(i_lanes), .i_last(i_last), .o_valid(o_valid4), .i_ready(i_ready),
        .o_val(o_val4), .o_count(o_count4)
    );

    lane_reduce_acc #(.LANES(LANES), .WIDTH(WIDTH), .ACC_COUNT(1)) dut1 (
        .i_clk(clk), .i_reset(rst), .i_valid(i_valid), .o_ready(o_ready1),
        .i_lanes(i_lanes), .i_last(i_last), .o_valid(o_valid1), .i_ready(i_ready),
        .o_val(o_val1), .o_count(o_count1)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] lane_sum(input logic [LW-1:0] v);
        logic [WIDTH-1:0] s;
        s = '0;
        for (int l = 0; l < LANES; l++) s = s + v[l*WIDTH +: WIDTH];
        return s;
    endfunction

    function automatic logic [LW-1:0] fill(input logic [WIDTH-1:0] v);
        logic [LW-1:0] r;
        for (int l = 0; l < LANES; l++) r[l*WIDTH +: WIDTH] = v;
        return r;
    endfunction

    // Reference model state: running sums and expected results {val, count}.
    logic [63:0]      q4[$];
    logic [63:0]      q1[$];
    logic [WIDTH-1:0] m_acc4 = '0, m_acc1 = '0;
    int               m_cnt4 = 0, m_cnt1 = 0;
    logic             hold4 = 1'b0, hold1 = 1'b0;
    logic [WIDTH-1:0] hv4, hv1;
    logic [2:0]       hc4;
    logic [0:0]       hc1;

    // Observe at negedge: what is seen here happens at the next posedge.
    always @(negedge clk) begin
        logic [63:0] e;
        check_val("ready4", {63'd0, o_ready4}, {63'd0, !(o_valid4 && !i_ready) && !rst});
        check_val("ready1", {63'd0, o_ready1}, {63'd0, !(o_valid1 && !i_ready) && !rst});
        if (rst) begin
            q4.delete();
            q1.delete();
            m_acc4 = '0; m_cnt4 = 0;
            m_acc1 = '0; m_cnt1 = 0;
            hold4 = 1'b0; hold1 = 1'b0;
        end else begin
            if (hold4) begin
                check_val("stall_valid4", {63'd0, o_valid4}, 64'd1);
                check_val("stall_val4", {32'd0, o_val4}, {32'd0, hv4});
                check_val("stall_cnt4", {61'd0, o_count4}, {61'd0, hc4});
            end
            if (hold1) begin
                check_val("stall_valid1", {63'd0, o_valid1}, 64'd1);
                check_val("stall_val1", {32'd0, o_val1}, {32'd0, hv1});
                check_val("stall_cnt1", {63'd0, o_count1}, {63'd0, hc1});
            end
            if (o_valid4 && i_ready) begin
                if (q4.size() == 0) check_val("extra_result4", 64'd1, 64'd0);
                else begin
                    e = q4.pop_front();
                    check_val("val4", {32'd0, o_val4}, {32'd0, e[63:32]});
                    check_val("cnt4", {61'd0, o_count4}, {32'd0, e[31:0]});
                end
            end
            if (o_valid1 && i_ready) begin
                if (q1.size() == 0) check_val("extra_result1", 64'd1, 64'd0);
                else begin
                    e = q1.pop_front();
                    check_val("val1", {32'd0, o_val1}, {32'd0, e[63:32]});
                    check_val("cnt1", {63'd0, o_count1}, {32'd0, e[31:0]});
                end
            end
            if (i_valid && o_ready4) begin
                m_acc4 = m_acc4 + lane_sum(i_lanes);
                m_cnt4++;
                if (m_cnt4 == 4 || i_last) begin
                    q4.push_back({m_acc4, 32'(m_cnt4)});
                    m_acc4 = '0; m_cnt4 = 0;
                end
            end
            if (i_valid && o_ready1) begin
                m_acc1 = m_acc1 + lane_sum(i_lanes);
                m_cnt1++;
                q1.push_back({m_acc1, 32'(m_cnt1)});
                m_acc1 = '0; m_cnt1 = 0;
            end
            hold4 = o_valid4 && !i_ready; hv4 = o_val4; hc4 = o_count4;
            hold1 = o_valid1 && !i_ready; hv1 = o_val1; hc1 = o_count1;
        end
    end

    // Present one beat until both instances take it; returns #1 after the accept edge.
    task automatic send_beat(input logic [LW-1:0] lanes, input logic last);
        int n;
        n = 0;
        i_valid = 1'b1; i_lanes = lanes; i_last = last;
        @(negedge clk);
        while (!(o_ready4 && o_ready1) && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50) check_val("send_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        i_valid = 1'b0; i_last = 1'b0;
    endtask

    task automatic drain(input int n);
        i_valid = 1'b0; i_ready = 1'b1; i_last = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for a result on one instance and compare it.
    task automatic wait_res(input logic sel4, input logic [31:0] ev, input int ec,
                            input string tag, input logic one_cycle);
        int  n;
        logic seen;
        n = 0; seen = 1'b0;
        while (n < 30 && !seen) begin
            @(posedge clk); #1;
            n++;
            seen = sel4 ? o_valid4 : o_valid1;
        end
        if (!seen) check_val({tag, "_timeout"}, 64'd0, 64'd1);
        else begin
            check_val({tag, "_val"}, {32'd0, (sel4 ? o_val4 : {31'd0, o_val1[0]} & 32'd0 | o_val1)}, {32'd0, ev});
            check_val({tag, "_cnt"}, {61'd0, (sel4 ? o_count4 : {2'd0, o_count1})}, 64'(ec));
            if (one_cycle) begin
                @(posedge clk); #1;
                check_val({tag, "_one_cycle"}, {63'd0, (sel4 ? o_valid4 : o_valid1)}, 64'd0);
            end
        end
    endtask

    initial begin
        logic [LW-1:0] v;
        int            idx, c;
        logic          acc;

        rst = 1'b1; i_valid = 1'b0; i_last = 1'b0; i_ready = 1'b1; i_lanes = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_valid4", {63'd0, o_valid4}, 64'd0);
        check_val("rst_val4", {32'd0, o_val4}, 64'd0);
        check_val("rst_cnt4", {61'd0, o_count4}, 64'd0);
        check_val("rst_ready4", {63'd0, o_ready4}, 64'd0);
        check_val("rst_valid1", {63'd0, o_valid1}, 64'd0);
        rst = 1'b0;
        drain(2);

        // 1: four all-ones beats -> 256 / 4, valid for one cycle.
        for (int b = 0; b < 4; b++) send_beat(fill(32'd1), 1'b0);
        wait_res(1'b1, 32'd256, 4, "t1", 1'b1);
        drain(10);

        // 2: lane k = k, latency of STAGES+1 edges.
        for (int l = 0; l < LANES; l++) v[l*WIDTH +: WIDTH] = 32'(l);
        send_beat(v, 1'b1);
        for (int e = 1; e <= 7; e++) begin
            @(posedge clk); #1;
            if (e < 7) check_val("t2_early", {63'd0, o_valid1}, 64'd0);
        end
        check_val("t2_valid", {63'd0, o_valid1}, 64'd1);
        check_val("t2_val", {32'd0, o_val1}, 64'd2016);
        check_val("t2_cnt", {63'd0, o_count1}, 64'd1);
        drain(10);

        // 3: wrap modulo 2^WIDTH.
        send_beat(fill(32'hFFFF_FFFF), 1'b1);
        wait_res(1'b0, 32'hFFFF_FFC0, 1, "t3", 1'b0);
        drain(10);

        // 4: early close by i_last, then a single-beat result.
        send_beat(fill(32'd2), 1'b0);
        send_beat(fill(32'd3), 1'b1);
        wait_res(1'b1, 32'd320, 2, "t4a", 1'b0);
        drain(4);
        send_beat(fill(32'd1), 1'b1);
        wait_res(1'b1, 32'd64, 1, "t4b", 1'b0);
        drain(10);

        // 5: 20 continuous beats with downstream stalled for cycles 5..14.
        idx = 0; c = 0;
        while (idx < 20 && c < 200) begin
            i_ready = !(c >= 5 && c <= 14);
            i_valid = 1'b1; i_last = 1'b0;
            i_lanes = '0; i_lanes[WIDTH-1:0] = 32'(idx);
            @(negedge clk);
            acc = o_ready1;
            @(posedge clk); #1;
            if (acc) idx++;
            c++;
        end
        check_val("t5_sent", 64'(idx), 64'd20);
        drain(15);
        check_val("t5_drained", 64'(q1.size()), 64'd0);

        // 6: reset with beats in flight and a partial accumulation.
        send_beat(fill(32'd1), 1'b1);
        drain(2);
        send_beat(fill(32'd1), 1'b0);
        drain(9);
        for (int b = 0; b < 3; b++) send_beat(fill(32'($urandom_range(1, 9))), 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int e = 0; e < 12; e++) begin
            @(posedge clk); #1;
            check_val("t6_flush4", {63'd0, o_valid4}, 64'd0);
            check_val("t6_flush1", {63'd0, o_valid1}, 64'd0);
        end
        send_beat(fill(32'd1), 1'b1);
        wait_res(1'b0, 32'd64, 1, "t6", 1'b0);
        drain(10);

        // Random traffic against the models.
        for (int r = 0; r < 600; r++) begin
            i_valid = ($urandom % 4) != 0;
            i_last  = ($urandom % 4) == 0;
            i_ready = ($urandom % 3) != 0;
            for (int l = 0; l < LANES; l++)
                i_lanes[l*WIDTH +: WIDTH] = (r % 2 == 0) ? $urandom : 32'($urandom_range(0, 15));
            @(posedge clk); #1;
        end
        i_ready = 1'b1;
        send_beat(fill(32'd0), 1'b1);
        drain(30);
        check_val("final_drain4", 64'(q4.size()), 64'd0);
        check_val("final_drain1", 64'(q1.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
